// File: rtl/seq_stream_controller.sv
`default_nettype none
// ============================================================================
// Module   : seq_stream_controller
// Purpose  : Serializes a word MSB-first into a sequence detector and counts
//            its registered hits. Optional macro FIRST_HIT_POS_EN adds
//            first-hit position reporting.
// Revision : 1.0 - initial release
// ============================================================================
module seq_stream_controller #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              det_in,
  output logic              det_clear,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  hit_count,
  output logic              hit_flag,
  output logic [2:0]        state_out
`ifdef FIRST_HIT_POS_EN
  ,
  output logic [IDX_W-1:0]  first_hit_idx,
  output logic              first_hit_vld
`endif
);

  // One extra bit so the counter can reach WORD_W while in DRAIN.
  localparam int c_BIT_W = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WORD_W-1:0]   r_shift;
  logic [c_BIT_W-1:0]  r_bit_cnt;
  logic [CNT_W-1:0]    r_hit_cnt;
  logic [CNT_W-1:0]    w_hit_nxt;
  logic                r_hit_flag;
  logic                w_sample;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_CLEAR;
      S_CLEAR: w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_bit_cnt == c_BIT_W'(WORD_W - 1)) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // det_in lags bit_out by one cycle, so the first SHIFT cycle has nothing to sample.
  always_comb begin
    w_sample  = det_in && (((r_state == S_SHIFT) && (r_bit_cnt != '0)) ||
                           (r_state == S_DRAIN));
    w_hit_nxt = r_hit_cnt;
    if (w_sample && (r_hit_cnt != '1)) w_hit_nxt = r_hit_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_hit_cnt  <= '0;
      r_hit_flag <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_shift <= word_in;
        end
        S_CLEAR: begin
          r_bit_cnt  <= '0;
          r_hit_cnt  <= '0;
          r_hit_flag <= 1'b0;
        end
        S_SHIFT: begin
          r_shift    <= {r_shift[WORD_W-2:0], 1'b0};
          r_bit_cnt  <= r_bit_cnt + c_BIT_W'(1);
          r_hit_cnt  <= w_hit_nxt;
          r_hit_flag <= (w_hit_nxt != '0);
        end
        S_DRAIN: begin
          r_hit_cnt  <= w_hit_nxt;
          r_hit_flag <= (w_hit_nxt != '0);
        end
        default: ;
      endcase
    end
  end

`ifdef FIRST_HIT_POS_EN
  logic [IDX_W-1:0] r_first_idx;
  logic             r_first_vld;

  // The sampled hit belongs to the bit shown one cycle earlier: index = counter - 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_first_idx <= '0;
      r_first_vld <= 1'b0;
    end else if (r_state == S_CLEAR) begin
      r_first_idx <= '0;
      r_first_vld <= 1'b0;
    end else if (w_sample && !r_first_vld) begin
      r_first_idx <= IDX_W'(r_bit_cnt - c_BIT_W'(1));
      r_first_vld <= 1'b1;
    end
  end

  assign first_hit_idx = r_first_idx;
  assign first_hit_vld = r_first_vld;
`endif

  assign det_clear = (r_state == S_CLEAR);
  assign bit_valid = (r_state == S_SHIFT);
  assign bit_out   = (r_state == S_SHIFT) && r_shift[WORD_W-1];
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign hit_count = r_hit_cnt;
  assign hit_flag  = r_hit_flag;
  assign state_out = r_state;

endmodule
`default_nettype wire

// File: tb/tb_seq_stream_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_stream_controller
// Purpose  : Directed self-checking bench; echo detector models on two DUTs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_stream_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] word_in;

  logic       det_a, det_clear_a, bit_out_a, bit_valid_a, busy_a, done_a, hit_flag_a;
  logic [3:0] hit_count_a;
  logic [2:0] state_a;
  logic       det_b, det_clear_b, bit_out_b, bit_valid_b, busy_b, done_b, hit_flag_b;
  logic [2:0] hit_count_b;
  logic [2:0] state_b;
`ifdef FIRST_HIT_POS_EN
  logic [2:0] fidx_a, fidx_b;
  logic       fvld_a, fvld_b;
`endif

  int n_pass = 0;
  int n_total = 0;

  int         obs_busy, obs_done_cyc, obs_done_n, obs_clr_cyc, obs_clr_n, obs_nbits;
  logic [7:0] obs_bits;
  logic [2:0] obs_st [0:20];

  always #5 clk = ~clk;

  seq_stream_controller #(.WORD_W(8), .CNT_W(4), .IDX_W(3)) u_dut (
    .clk(clk), .reset(reset), .start(start), .word_in(word_in), .det_in(det_a),
    .det_clear(det_clear_a), .bit_out(bit_out_a), .bit_valid(bit_valid_a),
    .busy(busy_a), .done(done_a), .hit_count(hit_count_a), .hit_flag(hit_flag_a),
    .state_out(state_a)
`ifdef FIRST_HIT_POS_EN
    , .first_hit_idx(fidx_a), .first_hit_vld(fvld_a)
`endif
  );

  seq_stream_controller #(.WORD_W(8), .CNT_W(3), .IDX_W(3)) u_sat (
    .clk(clk), .reset(reset), .start(start), .word_in(word_in), .det_in(det_b),
    .det_clear(det_clear_b), .bit_out(bit_out_b), .bit_valid(bit_valid_b),
    .busy(busy_b), .done(done_b), .hit_count(hit_count_b), .hit_flag(hit_flag_b),
    .state_out(state_b)
`ifdef FIRST_HIT_POS_EN
    , .first_hit_idx(fidx_b), .first_hit_vld(fvld_b)
`endif
  );

  // Echo detectors: detected = previous stream bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      det_a <= 1'b0;
      det_b <= 1'b0;
    end else begin
      det_a <= det_clear_a ? 1'b0 : bit_out_a;
      det_b <= det_clear_b ? 1'b0 : bit_out_b;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accepts a word, then records 20 cycles of outputs (cycle 1 = k+1).
  task automatic run_word(input logic [7:0] w, input int restart_at);
    obs_busy = 0; obs_done_cyc = -1; obs_done_n = 0;
    obs_clr_cyc = -1; obs_clr_n = 0; obs_nbits = 0; obs_bits = 8'h00;
    start = 1'b1; word_in = w;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      obs_st[c] = state_a;
      if (busy_a) obs_busy++;
      if (done_a) begin obs_done_n++; obs_done_cyc = c; end
      if (det_clear_a) begin obs_clr_n++; obs_clr_cyc = c; end
      if (bit_valid_a) begin obs_bits = {obs_bits[6:0], bit_out_a}; obs_nbits++; end
      if (c == restart_at) begin start = 1'b1; word_in = 8'hFF; end
      tick;
      start = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; word_in = 8'h00;
    #1;
    n_total++; if (state_a !== 3'd0) $display("FAIL rst_state: got %0d exp 0", state_a); else n_pass++;
    tick; tick;
    n_total++; if ({det_clear_a, bit_out_a, bit_valid_a, busy_a, done_a, hit_flag_a} !== 6'b0)
      $display("FAIL rst_outs: got %b exp 000000", {det_clear_a, bit_out_a, bit_valid_a, busy_a, done_a, hit_flag_a}); else n_pass++;
    n_total++; if (hit_count_a !== 4'd0) $display("FAIL rst_hits: got %0d exp 0", hit_count_a); else n_pass++;
    reset = 1'b0;
    tick;
    n_total++; if (state_a !== 3'd0 || busy_a !== 1'b0) $display("FAIL rst_idle: got state %0d busy %b exp 0 0", state_a, busy_a); else n_pass++;
  endtask

  task automatic test_b4;
    run_word(8'hB4, 0);
    n_total++; if (obs_nbits !== 8) $display("FAIL b4_nbits: got %0d exp 8", obs_nbits); else n_pass++;
    n_total++; if (obs_bits !== 8'hB4) $display("FAIL b4_bits: got %h exp b4", obs_bits); else n_pass++;
    n_total++; if (hit_count_a !== 4'd4) $display("FAIL b4_hits: got %0d exp 4", hit_count_a); else n_pass++;
    n_total++; if (hit_flag_a !== 1'b1) $display("FAIL b4_flag: got %b exp 1", hit_flag_a); else n_pass++;
    n_total++; if (obs_done_cyc !== 11) $display("FAIL b4_done_cyc: got %0d exp 11", obs_done_cyc); else n_pass++;
    n_total++; if (obs_done_n !== 1) $display("FAIL b4_done_n: got %0d exp 1", obs_done_n); else n_pass++;
    n_total++; if (obs_busy !== 11) $display("FAIL b4_busy: got %0d exp 11", obs_busy); else n_pass++;
  endtask

  task automatic test_zero;
    run_word(8'h00, 0);
    n_total++; if (hit_count_a !== 4'd0) $display("FAIL zero_hits: got %0d exp 0", hit_count_a); else n_pass++;
    n_total++; if (hit_flag_a !== 1'b0) $display("FAIL zero_flag: got %b exp 0", hit_flag_a); else n_pass++;
    n_total++; if (obs_done_n !== 1) $display("FAIL zero_done_n: got %0d exp 1", obs_done_n); else n_pass++;
    n_total++; if (obs_clr_n !== 1) $display("FAIL zero_clr_n: got %0d exp 1", obs_clr_n); else n_pass++;
    n_total++; if (obs_clr_cyc !== 1) $display("FAIL zero_clr_cyc: got %0d exp 1", obs_clr_cyc); else n_pass++;
  endtask

  task automatic test_saturate;
    run_word(8'hFF, 0);
    n_total++; if (hit_count_b !== 3'd7) $display("FAIL sat_hits3: got %0d exp 7", hit_count_b); else n_pass++;
    n_total++; if (hit_flag_b !== 1'b1) $display("FAIL sat_flag3: got %b exp 1", hit_flag_b); else n_pass++;
    n_total++; if (hit_count_a !== 4'd8) $display("FAIL sat_hits4: got %0d exp 8", hit_count_a); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [2:0] exp_st;
    run_word(8'hB4, 3);
    for (int c = 1; c <= 20; c++) begin
      exp_st = (c == 1) ? 3'd1 : (c <= 9) ? 3'd2 : (c == 10) ? 3'd3 : (c == 11) ? 3'd4 : 3'd0;
      n_total++; if (obs_st[c] !== exp_st) $display("FAIL b2b_state_c%0d: got %0d exp %0d", c, obs_st[c], exp_st); else n_pass++;
    end
    n_total++; if (hit_count_a !== 4'd4) $display("FAIL b2b_hits: got %0d exp 4", hit_count_a); else n_pass++;
    n_total++; if (obs_busy !== 11) $display("FAIL b2b_busy: got %0d exp 11", obs_busy); else n_pass++;
    run_word(8'h00, 11);
    n_total++; if (obs_busy !== 11) $display("FAIL b2b_done_start_busy: got %0d exp 11", obs_busy); else n_pass++;
    n_total++; if (obs_done_n !== 1) $display("FAIL b2b_done_start_n: got %0d exp 1", obs_done_n); else n_pass++;
  endtask

  task automatic test_mid_reset;
    int nd, nb;
    start = 1'b1; word_in = 8'hB4;
    tick;
    start = 1'b0;
    repeat (5) tick;
    n_total++; if (state_a !== 3'd2) $display("FAIL mr_pre_state: got %0d exp 2", state_a); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if (state_a !== 3'd0) $display("FAIL mr_state: got %0d exp 0", state_a); else n_pass++;
    n_total++; if ({det_clear_a, bit_out_a, bit_valid_a, busy_a, done_a, hit_flag_a} !== 6'b0)
      $display("FAIL mr_outs: got %b exp 000000", {det_clear_a, bit_out_a, bit_valid_a, busy_a, done_a, hit_flag_a}); else n_pass++;
    n_total++; if (hit_count_a !== 4'd0) $display("FAIL mr_hits: got %0d exp 0", hit_count_a); else n_pass++;
    tick;
    reset = 1'b0;
    nd = 0; nb = 0;
    for (int c = 0; c < 12; c++) begin
      if (done_a) nd++;
      if (busy_a) nb++;
      tick;
    end
    n_total++; if (nd !== 0 || nb !== 0) $display("FAIL mr_quiet: got done %0d busy %0d exp 0 0", nd, nb); else n_pass++;
    run_word(8'hB4, 0);
    n_total++; if (hit_count_a !== 4'd4) $display("FAIL mr_rerun_hits: got %0d exp 4", hit_count_a); else n_pass++;
    n_total++; if (obs_done_cyc !== 11) $display("FAIL mr_rerun_done: got %0d exp 11", obs_done_cyc); else n_pass++;
  endtask

`ifdef FIRST_HIT_POS_EN
  task automatic test_first_hit;
    run_word(8'h20, 0);
    n_total++; if (fidx_a !== 3'd2) $display("FAIL fh_idx: got %0d exp 2", fidx_a); else n_pass++;
    n_total++; if (fvld_a !== 1'b1) $display("FAIL fh_vld: got %b exp 1", fvld_a); else n_pass++;
    n_total++; if (hit_count_a !== 4'd1) $display("FAIL fh_hits: got %0d exp 1", hit_count_a); else n_pass++;
    run_word(8'h00, 0);
    n_total++; if (fvld_a !== 1'b0) $display("FAIL fh_none_vld: got %b exp 0", fvld_a); else n_pass++;
    n_total++; if (fidx_a !== 3'd0) $display("FAIL fh_none_idx: got %0d exp 0", fidx_a); else n_pass++;
  endtask
`endif

  initial begin
    test_reset;
    test_b4;
    test_zero;
    test_saturate;
    test_back_to_back;
    test_mid_reset;
`ifdef FIRST_HIT_POS_EN
    test_first_hit;
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
